// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes integer ops, issues them to a combinational ALU and returns the result on a valid/ready channel
module alu_issue_ctrl #(
  parameter int XLEN = 32,
  parameter int ALU_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      req_opcode,
  input  logic [2:0]      req_funct3,
  input  logic [6:0]      req_funct7,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [XLEN-1:0] req_imm,
  output logic [XLEN-1:0] alu_inp1,
  output logic [XLEN-1:0] alu_inp2,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_out1,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_illegal
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] ctrl;
  logic legal;
  logic is_r, is_i, f7z, f7s, immz, shift;
  logic [XLEN-1:0] op2, inp2;
  assign is_r = req_opcode == 7'b0110011;
  assign is_i = req_opcode == 7'b0010011;
  assign f7z = req_funct7 == 7'b0000000;
  assign f7s = req_funct7 == 7'b0100000;
  assign immz = req_imm[11:5] == 7'b0;
  assign shift = req_funct3[1:0] == 2'b01;
  assign op2 = is_r ? req_rs2 : req_imm;
  assign inp2 = shift ? {{(XLEN-5){1'b0}}, op2[4:0]} : op2;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  // map funct3/funct7 to the ALU ctrl code and flag anything the ALU cannot do
  always_comb begin
    ctrl = 4'b1000;
    legal = 1'b0;
    case (req_funct3)
      3'b000: begin
        ctrl = (is_r & f7s) ? 4'b1010 : 4'b1000;
        legal = is_i | (is_r & (f7z | f7s));
      end
      3'b111: begin
        ctrl = 4'b1100;
        legal = is_i | (is_r & f7z);
      end
      3'b110: begin
        ctrl = 4'b1101;
        legal = is_i | (is_r & f7z);
      end
      3'b001: begin
        ctrl = 4'b0000;
        legal = (is_r & f7z) | (is_i & immz);
      end
      3'b101: begin
        ctrl = 4'b0010;
        legal = (is_r & f7z) | (is_i & immz);
      end
      default: ;
    endcase
  end
  // issue / settle / respond sequencing; illegal ops skip the ALU entirely
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      rsp_data <= '0;
      rsp_illegal <= 1'b0;
      alu_inp1 <= '0;
      alu_inp2 <= '0;
      alu_ctrl <= 4'b1000;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          if (legal) begin
            alu_inp1 <= req_rs1;
            alu_inp2 <= inp2;
            alu_ctrl <= ctrl;
            cnt <= 4'(ALU_LAT - 1);
            state <= EXEC;
          end else begin
            rsp_data <= '0;
            rsp_illegal <= 1'b1;
            state <= RESP;
          end
        end
        EXEC: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          rsp_data <= alu_out1;
          rsp_illegal <= 1'b0;
          state <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
